// File: rtl/router_pkg.sv
// Shared definitions for the router transmit path: widths, FSM state encoding and the
// header packing helper used by router_pkt_tx and the router_fsm benches.
package router_pkg;

    localparam int unsigned DATA_WIDTH         = 8;
    localparam int unsigned LEN_WIDTH          = 6;
    localparam int unsigned DEFAULT_GAP_CYCLES = 2;
    localparam int unsigned BUF_DEPTH          = 64;
    localparam int unsigned PTR_WIDTH          = $clog2(BUF_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StGap
    } tx_state_e;

    // Length occupies the upper bits, destination port the lower two.
    function automatic logic [DATA_WIDTH-1:0] make_header(input logic [LEN_WIDTH-1:0] len,
                                                          input logic [1:0]           addr);
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buffer.sv
// Single-clock payload buffer: write pointer fills it during LOAD, read pointer drains it
// during transmission. Read data is combinational so the next byte is ready without a bubble.
module router_tx_buffer
    import router_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q;
    logic [PTR_WIDTH-1:0]  rd_ptr_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers restart at every new packet so each payload lands at address 0.
    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a host payload, then sends header, payload and XOR parity
// to the router input port while honouring busy backpressure.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  cmd_err,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  busy,
    output logic                  pkt_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  tx_done
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_e             state_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [1:0]            addr_q;
    logic [LEN_WIDTH-1:0]  byte_cnt_q;
    logic [DATA_WIDTH-1:0] parity_q;
    logic [GapW-1:0]       gap_cnt_q;

    logic                  cmd_legal;
    logic                  consume;
    logic                  last_byte;
    logic                  buf_clear;
    logic                  buf_wr;
    logic                  buf_rd;
    logic [DATA_WIDTH-1:0] buf_data;

    assign cmd_ready = (state_q == StIdle);
    assign src_ready = (state_q == StLoad);

    assign cmd_legal = (cmd_len != '0) && (cmd_addr != 2'b11);
    assign consume   = !busy && ((state_q == StHeader) || (state_q == StPayload) ||
                                 (state_q == StParity));
    assign last_byte = (byte_cnt_q == len_q - LEN_WIDTH'(1));

    assign buf_clear = cmd_ready && cmd_valid && cmd_legal;
    assign buf_wr    = src_ready && src_valid;
    // The read pointer runs one byte ahead of data_out, so it advances on header consumption.
    assign buf_rd    = consume && ((state_q == StHeader) ||
                                   ((state_q == StPayload) && !last_byte));

    router_tx_buffer u_buffer (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (buf_clear),
        .wr_en   (buf_wr),
        .wr_data (src_data),
        .rd_en   (buf_rd),
        .rd_data (buf_data)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q    <= StIdle;
            len_q      <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            parity_q   <= '0;
            gap_cnt_q  <= '0;
            pkt_valid  <= 1'b0;
            data_out   <= '0;
            cmd_err    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            tx_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_legal) begin
                            len_q      <= cmd_len;
                            addr_q     <= cmd_addr;
                            byte_cnt_q <= '0;
                            state_q    <= StLoad;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (src_valid) begin
                        if (last_byte) begin
                            byte_cnt_q <= '0;
                            pkt_valid  <= 1'b1;
                            data_out   <= make_header(len_q, addr_q);
                            state_q    <= StHeader;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                StHeader: begin
                    if (!busy) begin
                        parity_q <= data_out;
                        data_out <= buf_data;
                        state_q  <= StPayload;
                    end
                end
                StPayload: begin
                    if (!busy) begin
                        parity_q <= parity_q ^ data_out;
                        if (last_byte) begin
                            pkt_valid <= 1'b0;
                            data_out  <= parity_q ^ data_out;
                            state_q   <= StParity;
                        end else begin
                            data_out   <= buf_data;
                            byte_cnt_q <= byte_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                StParity: begin
                    if (!busy) begin
                        tx_done   <= 1'b1;
                        data_out  <= '0;
                        gap_cnt_q <= '0;
                        state_q   <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: table vectors, hand-written corner sequences and
// randomized packets compared against a stream-level reference model.
module tb_router_pkt_tx;

    localparam int GAP = 2;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        int addr;
        int len;
        int pat;      // 0 explicit b0..b2, 1 incrementing, 2 random
        int b0;
        int b1;
        int b2;
        int mode;     // busy: 0 never, 1 random, 2 held at hold_idx for hold_n cycles
        int hold_idx;
        int hold_n;
        int exp_hold; // expected cycles the held byte is visible (0: not checked)
        bit is_err;
        bit known;    // exp_hdr/exp_par are fixed expectations
        int exp_hdr;
        int exp_par;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_addr = 2'd0;
    logic [5:0] cmd_len = 6'd0;
    logic       cmd_err;
    logic       src_valid = 1'b0;
    logic       src_ready;
    logic [7:0] src_data = 8'd0;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hdr_cyc = 0;
    int par_cyc = 0;

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_err   (cmd_err),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_data  (src_data),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    function automatic vec_t mk(int addr, int len, int pat, int b0, int b1, int b2, int mode,
                                int hidx, int hn, int eh, bit err, bit known, int hdr,
                                int par);
        vec_t v;
        v.addr = addr; v.len = len; v.pat = pat; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.mode = mode; v.hold_idx = hidx; v.hold_n = hn; v.exp_hold = eh;
        v.is_err = err; v.known = known; v.exp_hdr = hdr; v.exp_par = par;
        return v;
    endfunction

    function automatic byte_q_t make_payload(vec_t v);
        byte_q_t pl;
        int      ex [3];
        ex[0] = v.b0; ex[1] = v.b1; ex[2] = v.b2;
        for (int i = 0; i < v.len; i++) begin
            if (v.pat == 0) pl.push_back(8'(ex[i % 3]));
            else if (v.pat == 1) pl.push_back(8'(i));
            else pl.push_back(8'($urandom));
        end
        return pl;
    endfunction

    // Reference: header is len*4+addr, then the payload, then the XOR of everything sent.
    function automatic byte_q_t model_stream(int addr, int len, byte_q_t pl);
        byte_q_t    s;
        logic [7:0] p;
        p = 8'((len * 4 + addr) % 256);
        s.push_back(p);
        foreach (pl[i]) begin
            s.push_back(pl[i]);
            p = p ^ pl[i];
        end
        s.push_back(p);
        return s;
    endfunction

    task automatic send_cmd(input int a, input int l);
        int t = 0;
        while (!cmd_ready && t < 200) begin
            step();
            t++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_addr  = 2'(a);
        cmd_len   = 6'(l);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic load_payload(input byte_q_t pl, input bit gaps);
        int i = 0;
        int t = 0;
        check("src_ready_load", src_ready, 1);
        while (i < pl.size() && t < 1000) begin
            src_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            src_data  = src_valid ? pl[i] : 8'($urandom);
            step();
            if (src_valid) i++;
            t++;
        end
        src_valid = 1'b0;
        if (t >= 1000) check("load_timeout", 0, 1);
    endtask

    task automatic transmit(input byte_q_t ex, input int mode, input int hold_idx,
                            input int hold_n, output int held);
        int         k = 0;
        int         t = 0;
        int         vis = 0;
        int         hold_left = hold_n;
        int         g = 0;
        bit         err_seen = 1'b0;
        bit         prev_busy = 1'b0;
        logic [8:0] prev = '0;
        held = 0;
        hdr_cyc = cyc;
        check("hdr_valid", pkt_valid, 1);
        while (k < ex.size() && t < 4000) begin
            if (prev_busy) check("hold_while_busy", {pkt_valid, data_out}, prev);
            check("pkt_valid_level", pkt_valid, (k < ex.size() - 1) ? 1 : 0);
            if (mode == 1) busy = ($urandom_range(0, 2) == 0);
            else if (mode == 2) busy = (k == hold_idx) && (hold_left > 0);
            else busy = 1'b0;
            if (busy && mode == 2) hold_left--;
            // Noise on the host side that must be ignored outside IDLE / LOAD.
            cmd_valid = 1'($urandom);
            cmd_addr  = 2'($urandom);
            cmd_len   = 6'($urandom);
            src_valid = 1'($urandom);
            src_data  = 8'($urandom);
            err_seen  = err_seen | cmd_err;
            vis++;
            if (!busy) begin
                check("tx_byte", data_out, ex[k]);
                if (k == hold_idx) held = vis;
                if (k == ex.size() - 1) par_cyc = cyc;
                k++;
                vis = 0;
            end
            prev_busy = busy;
            prev = {pkt_valid, data_out};
            step();
            t++;
        end
        busy = 1'b0;
        cmd_valid = 1'b0;
        src_valid = 1'b0;
        if (t >= 4000) check("tx_timeout", 0, 1);
        check("ignored_cmd_no_err", err_seen | cmd_err, 0);
        check("tx_done_pulse", tx_done, 1);
        while (!cmd_ready && g < 50) begin
            check("gap_pkt_valid", pkt_valid, 0);
            step();
            g++;
            if (g == 1) check("tx_done_single", tx_done, 0);
        end
        check("gap_cycles", g, GAP);
    endtask

    task automatic run_vec(input vec_t v);
        byte_q_t pl;
        byte_q_t ex;
        int      held;
        send_cmd(v.addr, v.len);
        if (v.is_err) begin
            check("err_pulse", cmd_err, 1);
            check("err_stay_idle", cmd_ready, 1);
            check("err_no_pkt", pkt_valid, 0);
            step();
            check("err_pulse_end", cmd_err, 0);
            check("err_no_pkt2", pkt_valid, 0);
            check("err_no_load", src_ready, 0);
            return;
        end
        pl = make_payload(v);
        ex = model_stream(v.addr, v.len, pl);
        if (v.known) begin
            ex[0] = 8'(v.exp_hdr);
            ex[ex.size() - 1] = 8'(v.exp_par);
        end
        load_payload(pl, v.mode == 1);
        transmit(ex, v.mode, v.hold_idx, v.hold_n, held);
        if (v.exp_hold != 0) check("hold_cycles", held, v.exp_hold);
    endtask

    initial begin
        vec_t    vecs[$];
        byte_q_t pl;
        int      p1;

        vecs.push_back(mk(0, 3, 0, 'h11, 'h22, 'h33, 0, -1, 0, 0, 0, 1, 'h0C, 'h0C));
        vecs.push_back(mk(1, 2, 0, 'hAA, 'h55, 0, 2, 1, 3, 4, 0, 1, 'h09, 'hF6));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(3, 5, 0, 0, 0, 0, 0, -1, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(2, 1, 0, 'hFF, 0, 0, 0, -1, 0, 0, 0, 1, 'h06, 'hF9));
        vecs.push_back(mk(2, 63, 1, 0, 0, 0, 1, -1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4, 2, 0, 0, 0, 2, 5, 2, 3, 0, 0, 0, 0));

        // Reset state.
        step();
        step();
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_src_ready", src_ready, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_tx_done", tx_done, 0);
        resetn = 1'b1;
        step();

        // Reset in the middle of the payload abandons the packet.
        send_cmd(2, 10);
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        load_payload(pl, 1'b0);
        check("mid_hdr", data_out, 8'(10 * 4 + 2));
        step();
        step();
        check("mid_in_payload", pkt_valid, 1);
        check("mid_payload_byte", data_out, pl[1]);
        resetn = 1'b0;
        step();
        check("mid_rst_pkt_valid", pkt_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_src_ready", src_ready, 0);
        check("mid_rst_data_out", data_out, 0);
        resetn = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back single-byte packets: host reissues as soon as cmd_ready returns.
        run_vec(mk(1, 1, 2, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0));
        p1 = par_cyc;
        run_vec(mk(2, 1, 2, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0));
        // GAP cycles, then one IDLE cycle to accept and one LOAD cycle for the byte.
        check("b2b_spacing", hdr_cyc - p1 - 1, GAP + 2);

        for (int r = 0; r < 16; r++) begin
            run_vec(mk($urandom_range(0, 2), $urandom_range(1, 63), 2, 0, 0, 0, 1, -1, 0, 0,
                       0, 0, 0, 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
